// File: rtl/mipi_frame_packer_pkg.sv
// mipi_frame_packer_pkg: frame geometry and capture FSM states shared by the
// packer, the display-side unpacker and the framebuffer RAM sizing.
package mipi_frame_packer_pkg;
   localparam int H_ACTIVE       = 640;
   localparam int V_ACTIVE       = 480;
   localparam int WORDS_PER_LINE = H_ACTIVE / 4;
   localparam int FRAME_WORDS    = V_ACTIVE * WORDS_PER_LINE;
   localparam int ADDR_W         = $clog2(FRAME_WORDS);
   typedef enum logic [1:0] {IDLE, WAIT_LINE, ACTIVE_LINE} state_t;
endpackage

// File: rtl/mipi_frame_packer_if.sv
// mipi_frame_packer_if: receiver byte stream in, framebuffer port-A write bus out.
interface mipi_frame_packer_if #(parameter int ADDR_W = mipi_frame_packer_pkg::ADDR_W);
   logic [7:0]        byte_in;
   logic              byte_valid;
   logic              frame_start;
   logic              line_start;
   logic              frame_end;
   logic [31:0]       data_o;
   logic [ADDR_W-1:0] adress_out;
   logic              we_o;
   modport master (output byte_in, byte_valid, frame_start, line_start, frame_end,
                   input data_o, adress_out, we_o);
   modport slave  (input byte_in, byte_valid, frame_start, line_start, frame_end,
                   output data_o, adress_out, we_o);
endinterface

// File: rtl/mipi_frame_packer_byte_packer_4to1.sv
// mipi_frame_packer_byte_packer_4to1: gathers four bytes into a little-endian word;
// a byte arriving with clear is lane 0 of a fresh word.
module mipi_frame_packer_byte_packer_4to1 (
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        byte_valid,
   input  logic [7:0]  byte_in,
   output logic [31:0] word,
   output logic        word_valid
);
   logic [23:0] lanes;
   logic [1:0]  cnt;
   logic [1:0]  cnt_base;
   always_comb begin
      cnt_base   = clear ? 2'd0 : cnt;
      word_valid = byte_valid && cnt_base == 2'd3;
      word       = {byte_in, lanes};
   end
   // Bytes shift in from the top so after three of them lane 0 sits in [7:0].
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lanes <= '0;
         cnt   <= '0;
      end else if (byte_valid) begin
         lanes <= {byte_in, lanes[23:8]};
         cnt   <= cnt_base + 2'd1;
      end else if (clear) begin
         cnt <= '0;
      end
   end
endmodule

// File: rtl/mipi_frame_packer.sv
// mipi_frame_packer: packs the armed frame's Bayer bytes into 32-bit words and
// writes them into the framebuffer, cropped to the active window.
module mipi_frame_packer #(
   parameter int H_ACTIVE = mipi_frame_packer_pkg::H_ACTIVE,
   parameter int V_ACTIVE = mipi_frame_packer_pkg::V_ACTIVE,
   parameter int ADDR_W   = mipi_frame_packer_pkg::ADDR_W
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                capture_en,
   mipi_frame_packer_if.slave  bus,
   output logic                frame_done,
   output logic                sync_err,
   output logic [9:0]          line_idx
);
   import mipi_frame_packer_pkg::*;
   localparam int WPL  = H_ACTIVE / 4;
   localparam int WC_W = $clog2(WPL + 1);
   state_t            state;
   logic              drop;
   logic [WC_W-1:0]   word_cnt;
   logic              capturing;
   logic              last_line;
   logic              ls_ok;
   logic              clear;
   logic              accept;
   logic              word_valid;
   logic [31:0]       word;
   logic [ADDR_W-1:0] addr;
   // A line_start that opens a new line carries byte 0 of it; one past the last line is an overflow.
   always_comb begin
      capturing = state != IDLE;
      last_line = line_idx == 10'(V_ACTIVE - 1);
      ls_ok     = bus.line_start && !bus.frame_start && !bus.frame_end &&
                  (state == WAIT_LINE || (state == ACTIVE_LINE && !drop && !last_line));
      clear     = bus.frame_start || ls_ok;
      accept    = bus.byte_valid && !bus.frame_start &&
                  (ls_ok || (state == ACTIVE_LINE && !drop && !bus.line_start && word_cnt != WC_W'(WPL)));
      addr      = ADDR_W'(line_idx) * ADDR_W'(WPL) + ADDR_W'(word_cnt);
   end
   mipi_frame_packer_byte_packer_4to1 u_byte_packer_4to1 (
      .clk        (clk),
      .reset      (reset),
      .clear      (clear),
      .byte_valid (accept),
      .byte_in    (bus.byte_in),
      .word       (word),
      .word_valid (word_valid)
   );
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= IDLE;
         drop           <= 1'b0;
         word_cnt       <= '0;
         line_idx       <= '0;
         sync_err       <= 1'b0;
         frame_done     <= 1'b0;
         bus.we_o       <= 1'b0;
         bus.data_o     <= '0;
         bus.adress_out <= '0;
      end else begin
         frame_done <= bus.frame_end && capturing && !bus.frame_start;
         bus.we_o   <= word_valid;
         if (word_valid) begin
            bus.data_o     <= word;
            bus.adress_out <= addr;
            word_cnt       <= word_cnt + 1'b1;
         end
         if (bus.frame_start) begin
            if (capturing) sync_err <= 1'b1;
            state    <= capture_en ? WAIT_LINE : IDLE;
            line_idx <= '0;
            drop     <= 1'b0;
         end else if (bus.frame_end && capturing) begin
            state <= IDLE;
         end else if (bus.line_start && state == ACTIVE_LINE && (drop || last_line)) begin
            sync_err <= 1'b1;
            drop     <= 1'b1;
         end else if (ls_ok) begin
            state    <= ACTIVE_LINE;
            word_cnt <= '0;
            if (state == ACTIVE_LINE) line_idx <= line_idx + 10'd1;
         end
      end
   end
endmodule
